uart_fab_rx: RTL

- Fabric-side UART receiver. It deserialises the MSS UART TX line (8N1, LSB first) into bytes for fabric logic.
- Completes the fabric end of the MSS UART link.
- Received bytes are buffered in a small first-word-fall-through FIFO.
- Error conditions are reported on sticky flags, and a level interrupt is raised while data is pending.

---
 rtl/uart_fab_pkg.sv | 18 +
 rtl/uart_fab_rx_fifo.sv | 69 ++++++
 rtl/uart_fab_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_fab_pkg.sv
// Shared constants and FSM state type for the fabric-side UART receiver.
package uart_fab_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_fab_rx_fifo.sv
// First-word-fall-through byte FIFO: head is read combinationally from the
// registered read pointer; a push into a full FIFO is taken only alongside a pop.
module uart_fab_rx_fifo
    import uart_fab_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_BITS-1:0]      wdata_i,
    output logic [DATA_BITS-1:0]      rdata_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          level_q, level_d;
    logic                 empty_q, full_q;
    logic                 do_push, do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is cleared on reset so the head reads 0 until the first push.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_fab_rx.sv
// Fabric UART receiver (8N1, LSB first, 16x oversampling) feeding a small FWFT
// FIFO, with sticky framing/overrun flags and a data-pending interrupt.
module uart_fab_rx
    import uart_fab_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           FAB_CCC_GL0,
    input  logic                           FAB_RESET_N,
    input  logic                           RX,
    input  logic                           RD_EN,
    output logic [7:0]                     RD_DATA,
    output logic                           RX_EMPTY,
    output logic                           RX_FULL,
    output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL,
    output logic                           FRAMING_ERR,
    output logic                           OVERRUN_ERR,
    input  logic                           ERR_CLR,
    output logic                           INT
);

    logic                 sync1_q, rxs_q;
    rx_state_t            state_q, state_d;
    logic [11:0]          div_q, div_d;
    logic                 tick;
    logic [3:0]           scnt_q, scnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 fe_q, fe_d, fe_set;
    logic                 oe_q, oe_d, oe_set;
    logic                 fifo_empty, fifo_full;

    // Divider is parked at 0 while idle so ticks line up with the start edge.
    assign tick  = (state_q != IDLE) && (div_q == 12'(BAUD_DIV - 1));
    assign div_d = (state_q == IDLE || tick) ? '0 : div_q + 12'd1;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        if (tick) begin
            scnt_d = scnt_q + 4'd1;
        end
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    scnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick && scnt_q == MID_SAMPLE) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        scnt_d  = '0;
                        bidx_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && scnt_q == LAST_SAMPLE) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && scnt_q == LAST_SAMPLE) begin
                    if (rxs_q) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts the byte when the head is popped the same cycle.
    assign oe_set = push_q && fifo_full && !(RD_EN && !fifo_empty);
    assign fe_d   = fe_set || (fe_q && !ERR_CLR);
    assign oe_d   = oe_set || (oe_q && !ERR_CLR);

    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            fe_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            sync1_q <= RX;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            fe_q    <= fe_d;
            oe_q    <= oe_d;
        end
    end

    uart_fab_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (FAB_CCC_GL0),
        .rst_ni  (FAB_RESET_N),
        .push_i  (push_q),
        .pop_i   (RD_EN),
        .wdata_i (shift_q),
        .rdata_o (RD_DATA),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (FIFO_LEVEL)
    );

    assign RX_EMPTY    = fifo_empty;
    assign RX_FULL     = fifo_full;
    assign INT         = !fifo_empty;
    assign FRAMING_ERR = fe_q;
    assign OVERRUN_ERR = oe_q;

endmodule
